// File: rtl/sw_debounce_pkg.sv
// Shared types and helpers for the slide-switch debouncer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sw_debounce_pkg;

    // Per-bit qualification state: settled, or a differing level is being timed.
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } bit_state_t;

    // Width of the stability counter. It only has to hold 0..n-1, so
    // $clog2(n) bits suffice; never return zero for degenerate n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_if.sv
// Switch conditioning bundle: raw pins in, debounced level/change/busy out.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface sw_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sw_i;     // raw asynchronous switch pins
    logic [WIDTH-1:0] sw_o;     // debounced, registered level
    logic [WIDTH-1:0] sw_chg;   // one-cycle pulse per bit when sw_o changes
    logic             sw_busy;  // some bit is currently qualifying a change

    // Debouncer side.
    modport slave (
        input  sw_i,
        output sw_o,
        output sw_chg,
        output sw_busy
    );

    // Pin/driver side (board wrapper or testbench).
    modport master (
        output sw_i,
        input  sw_o,
        input  sw_chg,
        input  sw_busy
    );

endinterface : sw_debounce_if

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchronizer chain, then a stability-count FSM.
// Latency: SYNC_STAGES + DB_CYCLES edges from a held pin step to o_q change.
// Backpressure: none; a revert before acceptance just discards the qualification.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 1000000,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,      // asynchronous, active low
    input  logic i_raw,
    output logic o_q,
    output logic o_chg,
    output logic o_busy
);

    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    bit_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_q;
    logic                   r_chg;
    logic                   w_s;

    // Bring the raw pin into the clock domain; only the last stage is used.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Qualify a differing level for DB_CYCLES consecutive samples before
    // adopting it; any sample equal to the current output aborts the attempt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_chg   <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_s != r_q) begin
                        r_state <= ST_PEND;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_PEND: begin
                    if (w_s == r_q) begin
                        // Glitch: pin went back before it was accepted.
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                        r_q     <= w_s;
                        r_chg   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_chg  = r_chg;
    assign o_busy = (r_state == ST_PEND);

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Debounces WIDTH slide switches independently and reports level, change pulse and busy.
// Latency: SYNC_STAGES + DB_CYCLES edges from a held pin step to sw_o/sw_chg.
// Backpressure: none; outputs are registered levels/pulses with no handshake.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_CYCLES   = 1000000,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,   // asynchronous, active low
    sw_debounce_if.slave   bus
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_busy;

    // Bits never interact, so each gets its own synchronizer and FSM.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RESET_VAL   (RESET_VAL[k])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.sw_i[k]),
            .o_q    (w_q[k]),
            .o_chg  (w_chg[k]),
            .o_busy (w_busy[k])
        );
    end

    assign bus.sw_o    = w_q;
    assign bus.sw_chg  = w_chg;
    // Decoded from FSM state flops only; no path from the pins.
    assign bus.sw_busy = |w_busy;

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    localparam int W  = 2;
    localparam int SS = 2;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(W)) bus ();

    sw_debounce #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .DB_CYCLES   (DB),
        .RESET_VAL   ({W{1'b0}})
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // A bit accepts a new level once the synchronized pin has disagreed with
    // the current output for DB consecutive clock edges. The synchronizer is
    // a plain history of sampled pin values, SS deep.
    logic [W-1:0] m_hist [SS];
    logic [W-1:0] m_q;
    logic [W-1:0] m_chg;
    int           m_streak [W];

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = '0;
        m_q   = '0;
        m_chg = '0;
        for (int k = 0; k < W; k++) m_streak[k] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] seen;
        seen  = m_hist[SS-1];
        m_chg = '0;
        for (int k = 0; k < W; k++) begin
            if (seen[k] != m_q[k]) begin
                m_streak[k] = m_streak[k] + 1;
                if (m_streak[k] == DB) begin
                    m_q[k]      = seen[k];
                    m_chg[k]    = 1'b1;
                    m_streak[k] = 0;
                end
            end else begin
                m_streak[k] = 0;
            end
        end
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = bus.sw_i;
    endtask

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int k = 0; k < W; k++) if (m_streak[k] > 0) b = 1'b1;
        return b;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check("model sw_o",    32'(bus.sw_o),    32'(m_q));
        check("model sw_chg",  32'(bus.sw_chg),  32'(m_chg));
        check("model sw_busy", 32'(bus.sw_busy), 32'(model_busy()));
    endtask

    // Reset from a falling edge, release on a later falling edge with pins = v.
    task automatic do_reset(input logic [W-1:0] v);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        bus.sw_i = v;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] in;
        logic [W-1:0] o;
        logic [W-1:0] chg;
        logic         busy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int first_t;
        logic [W-1:0] first_v;
        int pulses;
        int hold [W];
        logic [W-1:0] cur;
        logic [W-1:0] bounce [10];

        // Clean step (entries 0..7): edge k+1 after the drive.
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{2'b01, 2'b00, 2'b00, 1'b0};
        tbl[2]  = '{2'b01, 2'b00, 2'b00, 1'b1};
        tbl[3]  = '{2'b01, 2'b00, 2'b00, 1'b1};
        tbl[4]  = '{2'b01, 2'b00, 2'b00, 1'b1};
        tbl[5]  = '{2'b01, 2'b01, 2'b01, 1'b0};
        tbl[6]  = '{2'b01, 2'b01, 2'b00, 1'b0};
        tbl[7]  = '{2'b01, 2'b01, 2'b00, 1'b0};
        // Three-cycle glitch on bit 1 (entries 8..14) is rejected.
        tbl[8]  = '{2'b11, 2'b01, 2'b00, 1'b0};
        tbl[9]  = '{2'b11, 2'b01, 2'b00, 1'b0};
        tbl[10] = '{2'b11, 2'b01, 2'b00, 1'b1};
        tbl[11] = '{2'b01, 2'b01, 2'b00, 1'b1};
        tbl[12] = '{2'b01, 2'b01, 2'b00, 1'b1};
        tbl[13] = '{2'b01, 2'b01, 2'b00, 1'b0};
        tbl[14] = '{2'b01, 2'b01, 2'b00, 1'b0};

        // 1: reset with pins high acts immediately and holds.
        rst = 1'b0;
        bus.sw_i = 2'b11;
        model_reset();
        #1;
        check("reset sw_o",    32'(bus.sw_o),    32'h0);
        check("reset sw_chg",  32'(bus.sw_chg),  32'h0);
        check("reset sw_busy", 32'(bus.sw_busy), 32'h0);
        repeat (10) begin
            tick();
            check("reset hold sw_o", 32'(bus.sw_o), 32'h0);
        end
        bus.sw_i = 2'b00;
        rst = 1'b1;
        tick();

        // 2 + 3: table-driven clean step and glitch.
        for (int i = 0; i < 15; i++) begin
            bus.sw_i = tbl[i].in;
            tick();
            check($sformatf("tbl[%0d] sw_o", i),    32'(bus.sw_o),    32'(tbl[i].o));
            check($sformatf("tbl[%0d] sw_chg", i),  32'(bus.sw_chg),  32'(tbl[i].chg));
            check($sformatf("tbl[%0d] sw_busy", i), 32'(bus.sw_busy), 32'(tbl[i].busy));
        end

        // 4: bounce 1,0,1,0,1 then hold; one pulse 6 edges after the last rise (edge 5).
        do_reset(2'b00);
        bounce = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        first_t = 0; pulses = 0;
        for (int t = 1; t <= 16; t++) begin
            bus.sw_i = (t <= 10) ? bounce[t-1] : 2'b01;
            tick();
            if (bus.sw_chg != '0) begin
                pulses++;
                if (first_t == 0) first_t = t;
            end
        end
        check("bounce pulse count", 32'(pulses), 32'd1);
        check("bounce pulse edge",  32'(first_t), 32'd10);
        check("bounce sw_o",        32'(bus.sw_o), 32'h1);

        // 5: parallel rise then parallel fall.
        do_reset(2'b00);
        for (int pass = 0; pass < 2; pass++) begin
            first_t = 0; first_v = '0;
            bus.sw_i = (pass == 0) ? 2'b11 : 2'b00;
            for (int t = 1; t <= 9; t++) begin
                tick();
                if (bus.sw_chg != '0 && first_t == 0) begin
                    first_t = t;
                    first_v = bus.sw_chg;
                end
            end
            check("parallel pulse edge", 32'(first_t), 32'd6);
            check("parallel pulse bits", 32'(first_v), 32'h3);
            check("parallel sw_o",       32'(bus.sw_o), (pass == 0) ? 32'h3 : 32'h0);
        end

        // 6: reset mid-qualification from sw_o=10, then full latency from release.
        do_reset(2'b10);
        repeat (8) tick();
        check("pre sw_o", 32'(bus.sw_o), 32'h2);
        bus.sw_i = 2'b11;
        repeat (3) tick();
        check("mid pend busy", 32'(bus.sw_busy), 32'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async rst sw_o",    32'(bus.sw_o),    32'h0);
        check("async rst sw_busy", 32'(bus.sw_busy), 32'h0);
        check("async rst sw_chg",  32'(bus.sw_chg),  32'h0);
        @(negedge clk);
        bus.sw_i = 2'b01;
        rst = 1'b1;
        first_t = 0; first_v = '0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t == 5) check("release edge5 sw_o", 32'(bus.sw_o), 32'h0);
            if (bus.sw_chg != '0 && first_t == 0) begin
                first_t = t;
                first_v = bus.sw_chg;
            end
        end
        check("release pulse edge", 32'(first_t), 32'd6);
        check("release pulse bits", 32'(first_v), 32'h1);

        // Random: per-bit levels held 1..7 cycles, occasional async reset.
        do_reset(2'b00);
        cur = '0;
        for (int k = 0; k < W; k++) hold[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < W; k++) begin
                if (hold[k] == 0) begin
                    cur[k]  = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 7));
                end
                hold[k]--;
            end
            bus.sw_i = cur;
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                #1;
                check("rand rst sw_o", 32'(bus.sw_o), 32'h0);
                @(negedge clk);
                rst = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sw_debounce
